// File: rtl/input_port_fifo_pkg.sv
// Shared router constants (FLIT_SIZE, LOG_PORTS_CNT, INBUF_DEFAULT_DEPTH) and types for the input buffer.
// Optional same-cycle bypass of an empty buffer is enabled by defining INBUF_BYPASS_EN.
`ifndef FLIT_SIZE
`define FLIT_SIZE 16
`endif
`ifndef LOG_PORTS_CNT
`define LOG_PORTS_CNT 3
`endif
`ifndef INBUF_DEFAULT_DEPTH
`define INBUF_DEFAULT_DEPTH 4
`endif

package input_port_fifo_pkg;
   localparam int FLIT_W = `FLIT_SIZE;
   localparam int INBUF_DEFAULT_DEPTH = `INBUF_DEFAULT_DEPTH;

   typedef logic [1:`FLIT_SIZE] flit_t;
endpackage

// File: rtl/input_port_fifo_inbuf_mem.sv
// DEPTH x FLIT_SIZE flit storage: synchronous write, asynchronous read, data not reset.
module inbuf_mem
   import input_port_fifo_pkg::*;
#(
   parameter int DEPTH = INBUF_DEFAULT_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wrEn,
   input  logic [PTR_W-1:0] wrAddr,
   input  flit_t            wrData,
   input  logic [PTR_W-1:0] rdAddr,
   output flit_t            rdData
);

   flit_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wrEn) mem[wrAddr] <= wrData;
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/input_port_fifo.sv
// Per-input-port circular flit buffer feeding the priority_port chain; pops on switch-allocation grant.
// Build with INBUF_BYPASS_EN to present an incoming flit at the head of an empty buffer in the same cycle.
module input_port_fifo
   import input_port_fifo_pkg::*;
#(
   parameter int DEPTH = INBUF_DEFAULT_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [1:`FLIT_SIZE] in_flit,
   output logic               in_ready,
   input  logic               grant,
   output logic               port_isNew,
   output logic [1:`FLIT_SIZE] port,
   output logic [PTR_W:0]     count,
   output logic               overflow
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   // Handshake: a flit transfers on an edge where in_valid && in_ready; in_valid
   // while full is dropped and latches overflow. grant pops only when port_isNew.
   logic [PTR_W-1:0] rdPtr, wrPtr;
   logic [PTR_W:0]   countQ;
   logic             overflowQ;
   logic             isEmpty, isFull;
   logic             push, doWrite, doPop, bypassHit;
   logic             headValid;
   flit_t            rdData, headFlit;

   assign isEmpty  = (countQ == '0);
   assign isFull   = (countQ == FULL_CNT);
   assign in_ready = !isFull;
   assign push     = in_valid && in_ready;

`ifdef INBUF_BYPASS_EN
   // Empty buffer offers the arriving flit directly; a grant consumes it without storing.
   assign bypassHit = isEmpty && in_valid && grant;
   assign headValid = !isEmpty || in_valid;
   assign headFlit  = isEmpty ? in_flit : rdData;
`else
   assign bypassHit = 1'b0;
   assign headValid = !isEmpty;
   assign headFlit  = rdData;
`endif

   assign doWrite = push && !bypassHit;
   assign doPop   = grant && !isEmpty;

   inbuf_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
      .clk    (clk),
      .wrEn   (doWrite),
      .wrAddr (wrPtr),
      .wrData (in_flit),
      .rdAddr (rdPtr),
      .rdData (rdData)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         countQ    <= '0;
         overflowQ <= 1'b0;
      end else begin
         if (doWrite) wrPtr <= wrPtr + PTR_W'(1);
         if (doPop)   rdPtr <= rdPtr + PTR_W'(1);
         if (doWrite && !doPop)      countQ <= countQ + (PTR_W+1)'(1);
         else if (doPop && !doWrite) countQ <= countQ - (PTR_W+1)'(1);
         if (in_valid && isFull) overflowQ <= 1'b1;
      end
   end

   assign port_isNew = headValid;
   assign port       = headValid ? headFlit : '0;
   assign count      = countQ;
   assign overflow   = overflowQ;

endmodule

// File: tb/tb_input_port_fifo.sv
// Scoreboard bench for input_port_fifo: directed fill/overflow/empty-grant/bypass cases plus random traffic.
// Follows INBUF_BYPASS_EN the same way the design does.
module tb_input_port_fifo;
  import input_port_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
`ifdef INBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  flit_t in_flit = '0;
  logic in_ready;
  logic grant = 1'b0;
  logic port_isNew;
  flit_t port;
  logic [PTR_W:0] count;
  logic overflow;

  input_port_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_flit    (in_flit),
    .in_ready   (in_ready),
    .grant      (grant),
    .port_isNew (port_isNew),
    .port       (port),
    .count      (count),
    .overflow   (overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: occupancy, sticky overflow, and the queue of flits still owed at the head
  int occ = 0;
  bit ovf_m = 1'b0;
  logic [FLIT_W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock cycle of stimulus, model advanced at the edge
  task automatic do_cycle(input bit v, input flit_t f, input bit g);
    bit acc, consumed;
    @(negedge clk);
    in_valid = v;
    in_flit  = f;
    grant    = g;
    acc      = v && (occ < DEPTH);
    consumed = BYP && v && g && (occ == 0);
    if (acc) exp_q.push_back(f);
    @(posedge clk);
    if (v && occ == DEPTH) ovf_m = 1'b1;
    if (acc && !consumed) occ++;
    if (g && occ > 0 && !(acc && !consumed && occ == 1 && !(occ - 1 > 0) && 0)) begin
    end
    if (g && (occ - ((acc && !consumed) ? 1 : 0)) > 0) occ--;
  endtask

  // asynchronous reset applied between edges, checked before any clock edge
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    grant = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_isNew", 32'(port_isNew), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_port", 32'(port), 0);
    occ = 0;
    ovf_m = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // scoreboard monitor: compares state every cycle, consumes the head whenever the DUT presents it with grant
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("isNew", 32'(port_isNew), 32'((occ != 0) || (BYP && in_valid)));
      chk("count", 32'(count), 32'(occ));
      chk("in_ready", 32'(in_ready), 32'(occ != DEPTH));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      if (port_isNew) begin
        if (exp_q.size() == 0) begin
          chk("head_unexpected", 32'(port), 32'hFFFF_FFFF);
        end else begin
          chk("head_flit", 32'(port), 32'(exp_q[0]));
          if (grant) void'(exp_q.pop_front());
        end
      end else begin
        chk("port_zero", 32'(port), 0);
      end
    end
  end

  initial begin
    flit_t fill_v[4];
    fill_v[0] = 16'h1111;
    fill_v[1] = 16'h2222;
    fill_v[2] = 16'h3333;
    fill_v[3] = 16'h4444;

    #3;
    chk("por_count", 32'(count), 0);
    chk("por_ready", 32'(in_ready), 1);
    @(negedge clk);
    #1 rst = 1'b0;

    // fill to full, then overflow attempt with a grant in the same cycle
    foreach (fill_v[i]) do_cycle(1'b1, fill_v[i], 1'b0);
    do_cycle(1'b0, '0, 1'b0);
    do_cycle(1'b1, 16'h5555, 1'b1);
    do_cycle(1'b1, 16'h6666, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b1);

    // grants on empty are ignored; next push is visible after one edge
    for (int i = 0; i < 3; i++) do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b1, 16'hBEEF, 1'b0);
    do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b0, '0, 1'b0);

    // simultaneous push+pop at count 2 across pointer wrap
    do_cycle(1'b1, 16'h0A01, 1'b0);
    do_cycle(1'b1, 16'h0A02, 1'b0);
    for (int i = 0; i < 10; i++) do_cycle(1'b1, flit_t'(16'hAA00 + i), 1'b1);
    do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b0, '0, 1'b1);

    // push+pop at count 1, then empty push with grant (bypass or buffered)
    do_cycle(1'b1, 16'h0B01, 1'b0);
    do_cycle(1'b1, 16'h0B02, 1'b1);
    do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b1, 16'hC0DE, 1'b1);
    do_cycle(1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b1);

    mid_reset();

    // random traffic, varying push/grant pressure per phase
    for (int ph = 0; ph < 4; ph++) begin
      int pv, pg;
      pv = (ph % 2 == 0) ? 80 : 40;
      pg = (ph < 2) ? 30 : 70;
      for (int i = 0; i < 120; i++)
        do_cycle($urandom_range(99, 0) < pv, flit_t'($urandom), $urandom_range(99, 0) < pg);
      if (ph == 1) mid_reset();
    end
    for (int i = 0; i < DEPTH + 1; i++) do_cycle(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
